clock_core: RTL and testbench
=============================

# clock_core

Time-of-day counter directly downstream of the timing generator. Consumes the 100 Hz clock-enable (CE10) and keeps seconds, minutes and hours in packed BCD. A three-state mode machine driven by debounced button pulses lets the user stop the clock and set hours and minutes. Outputs feed the display multiplexer.

## Interface
Parameters:
- TICKS_PER_SEC, default 100: CE10 pulses per second. Simulation benches override it to small values, e.g. 4.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- CE10  in  1  one-cycle enable at 100 Hz from the timing generator.
- MODE  in  1  one-cycle pulse, debounced upstream; advances the mode machine.
- UP  in  1  one-cycle pulse, debounced upstream; increments the selected field in set modes.
- SEC  out  8  seconds, BCD, 00–59.
- MIN  out  8  minutes, BCD, 00–59.
- HOUR  out  8  hours, BCD. Range 00–23, or 01–12 when 12-hour mode is compiled in.
- PM  out  1  PM flag. Constant 0 unless 12-hour mode is compiled in.
- STATE  out  2  mode: 0 RUN, 1 SET_HOUR, 2 SET_MIN. Used by the display for field blinking.
- TICK1S  out  1  one-cycle pulse on each seconds increment.

## Operation
- Internal prescaler `sub` counts 0..TICKS_PER_SEC-1 on CE10 and runs only in RUN.
- Second tick: CE10=1 and sub=TICKS_PER_SEC-1, in RUN. On a tick:
  - sub clears and SEC increments.
  - SEC 59→00 carries to MIN; MIN 59→00 carries to HOUR.
  - HOUR 23→00 in 24-hour mode.
- BCD arithmetic: low digit 9→0 carries to the high digit. Digits above 9 are never produced.
- Mode machine transitions, all on MODE pulses:
  - RUN→SET_HOUR.
  - SET_HOUR→SET_MIN.
  - SET_MIN→RUN. On this transition SEC and sub clear to 0.
- In SET_HOUR and SET_MIN, CE10 is ignored and time is frozen.
- UP in SET_HOUR increments HOUR with wrap and no carry.
- UP in SET_MIN increments MIN 59→00 with no carry to HOUR.
- UP is ignored in RUN.
- Simultaneous events:
  - MODE and UP in the same cycle: MODE wins, UP is dropped.
  - MODE and a tick in the same cycle in RUN: the tick is applied and the state becomes SET_HOUR.
- Reset values: SEC=00, MIN=00, HOUR=00 (12-hour mode: HOUR=12), PM=0, STATE=RUN, sub=0, TICK1S=0.

## Timing
- All outputs are registered.
- SEC/MIN/HOUR/TICK1S update on the clock edge that samples the tick, so they are visible the next cycle (1-cycle latency). Full carry ripple 23:59:59→00:00:00 completes in that same single edge.
- STATE and the UP-driven field increment take effect 1 cycle after the pulse.
- TICK1S is high for exactly 1 cycle per second, never in set modes.
- RST asserted mid-operation (any state, mid-carry) restores reset values on the next edge. It overrides CE10/MODE/UP.

## Configuration
- Macro `CLOCK_CORE_HOUR12_EN`.
- Defined: 12-hour format.
  - HOUR sequence 12,01,…,11,12.
  - PM toggles on 11→12, whether reached by carry or by UP.
  - Reset is 12 AM (HOUR=12, PM=0).
- Undefined: 24-hour format, 00–23, PM tied to 0.

## Structure
- Shared package `clock_pkg`:
  - STATE encoding constants RUN/SET_HOUR/SET_MIN.
  - BCD limit constants 8'h59, 8'h23, 8'h12, 8'h11.
- Sub-module `bcd_mod60`:
  - Two-digit BCD mod-60 counter with inputs CLK, RST, INC, CLR and outputs Q[7:0], CO. CO = INC & Q==8'h59.
  - Instantiated for SEC and MIN.
  - CO is used for the seconds→minutes carry only. In SET_MIN the MIN increment uses INC alone and CO is left unused.
- Hour counter and mode FSM are inline.

## Test plan
- Reset, then 100 CE10 pulses in RUN → SEC=01, one TICK1S pulse, MIN=00, HOUR=00.
- With TICKS_PER_SEC=4, preset 23:59:58, 8 CE10 pulses → 00:00:00, all carries on one edge.
- MODE, then UP×3, then MODE, UP×61, MODE → STATE back to RUN; HOUR=03, MIN=01, SEC=00. CE10 pulses during set modes leave the time unchanged.
- MODE and UP asserted in the same cycle in RUN → STATE=SET_HOUR, HOUR unchanged.
- RST pulsed during SET_MIN at 12:34:56 → next cycle reads 00:00:00 (12-hour build: 12:00:00), PM=0, STATE=RUN.
- `CLOCK_CORE_HOUR12_EN` build: preset 11:59:59 PM=0, one second tick → 12:00:00 PM=1. Then set mode with HOUR=12, UP → HOUR=01, PM unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared state encoding, BCD limits and BCD increment helper for the time-of-day counter.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_11 = 8'h11;
  localparam logic [7:0] BCD_01 = 8'h01;

  // Two-digit packed BCD +1; the caller handles the modulus wrap.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD mod-60 counter; CO flags an increment that wraps 59->00.
module bcd_mod60
  import clock_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       INC,
  input  logic       CLR,
  output logic [7:0] Q,
  output logic       CO
);

  assign CO = INC & (Q == BCD_59);

  always_ff @(posedge CLK) begin
    if (RST)      Q <= 8'h00;
    else if (CLR) Q <= 8'h00;
    else if (INC) Q <= (Q == BCD_59) ? 8'h00 : bcd_inc(Q);
  end

endmodule

// File: rtl/clock_core.sv
// Time-of-day counter with RUN/SET_HOUR/SET_MIN mode machine.
// Define CLOCK_CORE_HOUR12_EN for 12-hour format with PM flag.
module clock_core
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE10,
  input  logic       MODE,
  input  logic       UP,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
  output logic [7:0] HOUR,
  output logic       PM,
  output logic [1:0] STATE,
  output logic       TICK1S
);

  localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  state_t           state;
  logic [SUB_W-1:0] sub;
  logic             tick_c;
  logic             sec_co;
  logic             min_co;
  logic             sec_clr_c;
  logic             min_inc_c;
  logic             hour_inc_c;

  // MODE takes priority over UP in the same cycle.
  assign tick_c     = CE10 & (state == RUN) & (sub == SUB_MAX);
  assign sec_clr_c  = MODE & (state == SET_MIN);
  assign min_inc_c  = sec_co | (UP & ~MODE & (state == SET_MIN));
  assign hour_inc_c = (min_co & (state == RUN)) | (UP & ~MODE & (state == SET_HOUR));

  bcd_mod60 u_sec (
    .CLK (CLK),
    .RST (RST),
    .INC (tick_c),
    .CLR (sec_clr_c),
    .Q   (SEC),
    .CO  (sec_co)
  );

  bcd_mod60 u_min (
    .CLK (CLK),
    .RST (RST),
    .INC (min_inc_c),
    .CLR (1'b0),
    .Q   (MIN),
    .CO  (min_co)
  );

  assign STATE = state;

  // Mode machine, prescaler and seconds pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      sub    <= '0;
      TICK1S <= 1'b0;
    end else begin
      TICK1S <= tick_c;
      if ((state == RUN) && CE10) sub <= tick_c ? '0 : sub + SUB_W'(1);
      if (MODE) begin
        case (state)
          RUN:      state <= SET_HOUR;
          SET_HOUR: state <= SET_MIN;
          default: begin
            state <= RUN;
            sub   <= '0;
          end
        endcase
      end
    end
  end

`ifdef CLOCK_CORE_HOUR12_EN
  // 12-hour: 12,01..11,12; PM flips on 11->12.
  always_ff @(posedge CLK) begin
    if (RST) begin
      HOUR <= BCD_12;
      PM   <= 1'b0;
    end else if (hour_inc_c) begin
      HOUR <= (HOUR == BCD_12) ? BCD_01 : bcd_inc(HOUR);
      if (HOUR == BCD_11) PM <= ~PM;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST)             HOUR <= 8'h00;
    else if (hour_inc_c) HOUR <= (HOUR == BCD_23) ? 8'h00 : bcd_inc(HOUR);
  end

  assign PM = 1'b0;
`endif

endmodule

// File: tb/tb_clock_core.sv
// Self-checking bench for clock_core; covers both hour formats via CLOCK_CORE_HOUR12_EN.
module tb_clock_core;

  localparam int T = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE10 = 1'b0;
  logic       MODE = 1'b0;
  logic       UP = 1'b0;
  logic [7:0] SEC, MIN, HOUR;
  logic       PM;
  logic [1:0] STATE;
  logic       TICK1S;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  // Reference model: plain integers for time of day.
  int ms, mm, mh, msub, mst;
  bit mpm, mtick;

`ifdef CLOCK_CORE_HOUR12_EN
  localparam bit H12 = 1'b1;
`else
  localparam bit H12 = 1'b0;
`endif

  clock_core #(.TICKS_PER_SEC(T)) dut (
    .CLK(CLK), .RST(RST), .CE10(CE10), .MODE(MODE), .UP(UP),
    .SEC(SEC), .MIN(MIN), .HOUR(HOUR), .PM(PM), .STATE(STATE), .TICK1S(TICK1S)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] to_bcd(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_hour_inc();
    if (H12) begin
      mh = (mh % 12) + 1;
      if (mh == 12) mpm = ~mpm;
    end else begin
      mh = (mh + 1) % 24;
    end
  endtask

  task automatic model_reset();
    ms = 0; mm = 0; mh = H12 ? 12 : 0; mpm = 1'b0; msub = 0; mst = 0; mtick = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic cyc(input bit ce, input bit mode, input bit up, input bit rst);
    CE10 = ce; MODE = mode; UP = up; RST = rst;
    @(posedge CLK);
    if (rst) model_reset();
    else begin
      mtick = (mst == 0) && ce && (msub == T - 1);
      if (mst == 0 && ce) msub = mtick ? 0 : msub + 1;
      if (mtick) begin
        ms++;
        if (ms == 60) begin
          ms = 0; mm++;
          if (mm == 60) begin mm = 0; model_hour_inc(); end
        end
      end
      if (mode) begin
        if (mst == 2) begin ms = 0; msub = 0; end
        mst = (mst + 1) % 3;
      end else if (up) begin
        if (mst == 1) model_hour_inc();
        else if (mst == 2) mm = (mm + 1) % 60;
      end
    end
    @(negedge CLK);
    CE10 = 1'b0; MODE = 1'b0; UP = 1'b0; RST = 1'b0;
    chk("sec", SEC, to_bcd(ms));
    chk("min", MIN, to_bcd(mm));
    chk("hour", HOUR, to_bcd(mh));
    chk("pm", {7'd0, PM}, {7'd0, mpm});
    chk("state", {6'd0, STATE}, 8'(mst));
    chk("tick1s", {7'd0, TICK1S}, {7'd0, mtick});
    if (TICK1S) tick_cnt++;
  endtask

  task automatic ce_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic up_until_hour(input int tgt);
    for (int i = 0; i < 30 && mh != tgt; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic up_until_min(input int tgt);
    for (int i = 0; i < 70 && mm != tgt; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_sec", SEC, 8'h00);
    chk("rst_hour", HOUR, H12 ? 8'h12 : 8'h00);
    chk("rst_state", {6'd0, STATE}, 8'h00);

    // 100 CE10 pulses at 4 per second -> 25 seconds, 25 pulses.
    tick_cnt = 0;
    ce_n(100);
    chk("run100_sec", SEC, 8'h25);
    chk("run100_ticks", 8'(tick_cnt), 8'd25);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Set 03:01, CE10 ignored while setting, SEC cleared on return.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ce_n(9);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ce_n(9);
    chk("setmin_sec_frozen", SEC, 8'h25);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("set_hour", HOUR, 8'h03);
    chk("set_min", MIN, 8'h01);
    chk("set_sec", SEC, 8'h00);
    chk("set_state", {6'd0, STATE}, 8'h00);

    // Preset 23:59:00 (12h: 11:59:00 AM), run to xx:59:58, then carry through.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    up_until_hour(H12 ? 11 : 23);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    up_until_min(59);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ce_n(58 * T);
    chk("pre_sec", SEC, 8'h58);
    ce_n(2 * T);
    chk("wrap_sec", SEC, 8'h00);
    chk("wrap_min", MIN, 8'h00);
    chk("wrap_hour", HOUR, H12 ? 8'h12 : 8'h00);
    chk("wrap_pm", {7'd0, PM}, {7'd0, H12});
    chk("wrap_tick", {7'd0, TICK1S}, 8'h01);

    // UP in SET_HOUR from 12 (or 00) -> 01, PM unchanged.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("uphour", HOUR, 8'h01);
    chk("uphour_pm", {7'd0, PM}, {7'd0, H12});
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // MODE and UP together in RUN: MODE wins.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("modeup_state", {6'd0, STATE}, 8'h01);
    chk("modeup_hour", HOUR, 8'h01);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // MODE coinciding with a tick: tick applied, state advances.
    ce_n(T - 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("modetick_sec", SEC, 8'h01);
    chk("modetick_tick", {7'd0, TICK1S}, 8'h01);
    chk("modetick_state", {6'd0, STATE}, 8'h01);

    // Reach 12:34:56, enter SET_MIN, then reset.
    up_until_hour(12);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    up_until_min(34);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ce_n(56 * T);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_time", HOUR, 8'h12);
    chk("pre_rst_sec", SEC, 8'h56);
    chk("pre_rst_state", {6'd0, STATE}, 8'h02);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst2_sec", SEC, 8'h00);
    chk("rst2_min", MIN, 8'h00);
    chk("rst2_hour", HOUR, H12 ? 8'h12 : 8'h00);
    chk("rst2_pm", {7'd0, PM}, 8'h00);
    chk("rst2_state", {6'd0, STATE}, 8'h00);
    ce_n(2 * T);
    chk("post_rst_sec", SEC, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
